// File: rtl/hex_display_scanner_if.sv
`timescale 1ns/1ps
// hex_display_scanner_if
// Groups the display data path of hex_display_scanner into one bundle.
//   i_cnt   [39:0] value to display, captured on i_load
//   i_load         single-cycle capture strobe
//   i_blank        level, forces the display dark
//   o_seg   [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   o_dig   [9:0]  digit enables, active-low, one-cold
//   o_frame        one-cycle pulse per completed 10-digit scan
// master = the side that supplies the count (upstream / testbench),
// slave  = the scanner itself.
interface hex_display_scanner_if;
  logic [39:0] i_cnt;
  logic        i_load;
  logic        i_blank;
  logic [6:0]  o_seg;
  logic [9:0]  o_dig;
  logic        o_frame;

  modport master (
    output i_cnt, i_load, i_blank,
    input  o_seg, o_dig, o_frame
  );

  modport slave (
    input  i_cnt, i_load, i_blank,
    output o_seg, o_dig, o_frame
  );
endinterface

// File: rtl/hex_display_scanner.sv
`timescale 1ns/1ps
// hex_display_scanner
// Multiplexed 10-digit seven-segment driver for a 40-bit hex count.
// A prescaler divides i_clk into digit slots of CLK_DIV clocks; each slot
// lights one digit. New counts are staged in a pending register and only
// transferred to the displayed value at a frame boundary, so one scan never
// mixes digits of two different counts.
//   i_clk    sole clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      slave side of hex_display_scanner_if (i_cnt, i_load, i_blank
//            in; o_seg, o_dig, o_frame out, all outputs registered)
// Parameters:
//   CLK_DIV      clocks per digit slot (>= 2)
//   LZ_SUPPRESS  1 blanks leading zero digits (digit 0 always lit)
module hex_display_scanner #(
  parameter int CLK_DIV     = 50000,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  hex_display_scanner_if.slave  bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  // Active-low hex glyphs, {g,f,e,d,c,b,a}; b and d are lowercase.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] presc_r;
  logic [3:0]    idx_r;
  logic [39:0]   pend_r;
  logic          pend_valid_r;
  logic [39:0]   shown_r;
  logic [6:0]    seg_r;
  logic [9:0]    dig_r;
  logic          frame_r;

  logic          tick_s;
  logic          boundary_s;
  logic [39:0]   shifted_s;
  logic [3:0]    nib_s;
  logic          lz_blank_s;
  logic [6:0]    seg_nxt_s;
  logic [9:0]    dig_nxt_s;

  // Slot tick and frame boundary (last slot of digit 9).
  always_comb begin
    tick_s     = (presc_r == PRESC_LAST);
    boundary_s = tick_s && (idx_r == 4'd9);
  end

  // Select the current digit's nibble and decide what the segments show next.
  always_comb begin
    // Shifting the current nibble to the bottom also leaves exactly the
    // nibbles idx..9 in the word, so a zero word means "leading zero".
    shifted_s = shown_r >> {idx_r, 2'b00};
    nib_s     = shifted_s[3:0];
    if ((LZ_SUPPRESS != 0) && (idx_r != 4'd0) && (shifted_s == 40'd0)) begin
      lz_blank_s = 1'b1;
    end else begin
      lz_blank_s = 1'b0;
    end
    if (bus.i_blank) begin
      seg_nxt_s = 7'h7F;
      dig_nxt_s = 10'h3FF;
    end else begin
      dig_nxt_s = ~(10'd1 << idx_r);
      if (lz_blank_s) begin
        seg_nxt_s = 7'h7F;
      end else begin
        seg_nxt_s = hex_glyph(nib_s);
      end
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_r <= '0;
      idx_r   <= 4'd0;
    end else if (tick_s) begin
      presc_r <= '0;
      idx_r   <= (idx_r == 4'd9) ? 4'd0 : idx_r + 4'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Pending / shown registers; shown only changes at a frame boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_r       <= 40'd0;
      pend_valid_r <= 1'b0;
      shown_r      <= 40'd0;
    end else if (boundary_s) begin
      // A strobe landing on the boundary bypasses the pending stage.
      if (bus.i_load) begin
        shown_r <= bus.i_cnt;
        pend_r  <= bus.i_cnt;
      end else if (pend_valid_r) begin
        shown_r <= pend_r;
      end else begin
        shown_r <= shown_r;
      end
      pend_valid_r <= 1'b0;
    end else if (bus.i_load) begin
      pend_r       <= bus.i_cnt;
      pend_valid_r <= 1'b1;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_r   <= 7'h7F;
      dig_r   <= 10'h3FF;
      frame_r <= 1'b0;
    end else begin
      seg_r   <= seg_nxt_s;
      dig_r   <= dig_nxt_s;
      frame_r <= boundary_s;
    end
  end

  assign bus.o_seg   = seg_r;
  assign bus.o_dig   = dig_r;
  assign bus.o_frame = frame_r;

endmodule
